// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and the ARP transmitter state encoding.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [15:0] ARP_OP_REQ      = 16'd1;
    localparam logic [15:0] ARP_OP_REPLY    = 16'd2;
    localparam logic [15:0] ARP_HTYPE       = 16'd1;
    localparam logic [15:0] ARP_PTYPE       = 16'h0800;
    localparam logic [7:0]  ARP_HLEN        = 8'd6;
    localparam logic [7:0]  ARP_PLEN        = 8'd4;
    localparam int          ETH_MIN_PAYLOAD = 46;
    localparam int          ETH_IFG         = 12;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;

    localparam int PREAMBLE_LEN = 8;
    localparam int ETH_HEAD_LEN = 14;
    localparam int ARP_LEN      = 28;
    localparam int PAD_LEN      = ETH_MIN_PAYLOAD - ARP_LEN;
    localparam int FCS_LEN      = 4;

    typedef enum logic [6:0] {
        ST_IDLE     = 7'b000_0001,
        ST_PREAMBLE = 7'b000_0010,
        ST_ETH_HEAD = 7'b000_0100,
        ST_ARP_DATA = 7'b000_1000,
        ST_PAD      = 7'b001_0000,
        ST_FCS      = 7'b010_0000,
        ST_IFG      = 7'b100_0000
    } arp_tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 (reflected form, poly 0x04C11DB7); crc_next is the
// combinational update of crc_data with the current byte.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        crc_en,
    input  logic        crc_clr,
    input  logic [7:0]  data,
    output logic [31:0] crc_data,
    output logic [31:0] crc_next
);

    localparam logic [31:0] POLY_REFL = 32'hEDB8_8320;

    always_comb begin : crc_step
        logic [31:0] c;
        c = crc_data ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        crc_next = c;
    end

    always_ff @(posedge clk) begin
        if (rst || crc_clr) begin
            crc_data <= CRC32_INIT;
        end else if (crc_en) begin
            crc_data <= crc_next;
        end
    end

endmodule

// File: rtl/arp_tx.sv
// ARP request/reply frame generator for the GMII TX path: preamble, header,
// ARP body, padding to 60 bytes and FCS, followed by the inter-frame gap.
module arp_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arp_tx_en,
    input  logic        arp_tx_type,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam logic [4:0] PREAMBLE_LAST = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0] HEAD_LAST     = 5'(ETH_HEAD_LEN - 1);
    localparam logic [4:0] ARP_LAST      = 5'(ARP_LEN - 1);
    localparam logic [4:0] PAD_LAST      = 5'(PAD_LEN - 1);
    localparam logic [4:0] FCS_LAST      = 5'(FCS_LEN - 1);
    localparam logic [4:0] IFG_LAST      = 5'(ETH_IFG - 1);

    arp_tx_state_t state, state_next;
    logic [4:0]    cnt, cnt_next;
    logic          type_q;
    logic [47:0]   des_mac_q;
    logic [31:0]   des_ip_q;
    logic          start;
    logic          crc_cov;
    logic          crc_en_q;
    logic          tx_en_next;
    logic [7:0]    txd_next;
    logic [31:0]   crc_data, crc_next;
    logic [111:0]  eth_head;
    logic [223:0]  arp_body;
    logic [3:0]    head_idx;
    logic [4:0]    arp_idx;

    assign eth_head = {type_q ? des_mac_q : 48'hFFFF_FFFF_FFFF, BOARD_MAC, ETH_TYPE_ARP};
    assign arp_body = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN,
                       type_q ? ARP_OP_REPLY : ARP_OP_REQ,
                       BOARD_MAC, BOARD_IP,
                       type_q ? des_mac_q : 48'h0, des_ip_q};
    assign head_idx = HEAD_LAST[3:0] - cnt[3:0];
    assign arp_idx  = ARP_LAST - cnt;

    // The CRC is fed from the registered output byte, so the final PAD byte is
    // only folded in combinationally when the first FCS byte is chosen.
    crc32_d8 u_crc (
        .clk      (clk),
        .rst      (rst),
        .crc_en   (crc_en_q),
        .crc_clr  (start),
        .data     (gmii_txd),
        .crc_data (crc_data),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            crc_en_q   <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            type_q     <= 1'b0;
            des_mac_q  <= '0;
            des_ip_q   <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            gmii_tx_en <= tx_en_next;
            gmii_txd   <= txd_next;
            crc_en_q   <= crc_cov;
            tx_busy    <= (state != ST_IDLE);
            tx_done    <= (state == ST_IFG) && (cnt == 5'd0);
            if (start) begin
                type_q    <= arp_tx_type;
                des_mac_q <= des_mac;
                des_ip_q  <= des_ip;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 5'd1;
        tx_en_next = 1'b0;
        txd_next   = 8'h00;
        crc_cov    = 1'b0;
        start      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (arp_tx_en) begin
                    start      = 1'b1;
                    state_next = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                tx_en_next = 1'b1;
                txd_next   = (cnt == PREAMBLE_LAST) ? ETH_SFD : ETH_PREAMBLE;
                if (cnt == PREAMBLE_LAST) begin
                    state_next = ST_ETH_HEAD;
                    cnt_next   = '0;
                end
            end
            ST_ETH_HEAD: begin
                tx_en_next = 1'b1;
                crc_cov    = 1'b1;
                txd_next   = eth_head[{head_idx, 3'b000} +: 8];
                if (cnt == HEAD_LAST) begin
                    state_next = ST_ARP_DATA;
                    cnt_next   = '0;
                end
            end
            ST_ARP_DATA: begin
                tx_en_next = 1'b1;
                crc_cov    = 1'b1;
                txd_next   = arp_body[{arp_idx, 3'b000} +: 8];
                if (cnt == ARP_LAST) begin
                    state_next = ST_PAD;
                    cnt_next   = '0;
                end
            end
            ST_PAD: begin
                tx_en_next = 1'b1;
                crc_cov    = 1'b1;
                if (cnt == PAD_LAST) begin
                    state_next = ST_FCS;
                    cnt_next   = '0;
                end
            end
            ST_FCS: begin
                tx_en_next = 1'b1;
                case (cnt[1:0])
                    2'd0:    txd_next = ~crc_next[7:0];
                    2'd1:    txd_next = ~crc_data[15:8];
                    2'd2:    txd_next = ~crc_data[23:16];
                    default: txd_next = ~crc_data[31:24];
                endcase
                if (cnt == FCS_LAST) begin
                    state_next = ST_IFG;
                    cnt_next   = '0;
                end
            end
            ST_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule
